// File: rtl/audio_pkg.sv
// Shared types, register map and helpers for the multi-voice tone generator.
package audio_pkg;

   typedef enum logic [1:0] {
      SAW    = 2'd0,
      TRI    = 2'd1,
      SQUARE = 2'd2,
      NOISE  = 2'd3
   } wave_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } seq_state_t;

   localparam logic [2:0] REG_VOL    = 3'd0;
   localparam logic [2:0] REG_PAN    = 3'd1;
   localparam logic [2:0] REG_PER_LO = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_LEN    = 3'd4;
   localparam logic [2:0] REG_DUTY   = 3'd5;

   localparam logic [14:0] LFSR_SEED = 15'h7FFF;

   // Clamp a signed value to the range of a w-bit two's complement number.
   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample mapping, shared by all voice slots.
module wave_shaper
   import audio_pkg::*;
(
   input  logic [7:0]        p,
   input  wave_t             wave,
   input  logic [7:0]        duty,
   input  logic              lfsr_bit,
   output logic signed [7:0] s
);

   logic [7:0] p2;

   always_comb begin
      p2 = {p[6:0], 1'b0};
      s  = '0;
      case (wave)
         SAW:     s = p ^ 8'h80;
         TRI:     s = (p[7] ? ~p2 : p2) ^ 8'h80;
         SQUARE:  s = (p < duty) ? 8'h7F : 8'h80;
         NOISE:   s = lfsr_bit ? 8'h7F : 8'h81;
         default: s = '0;
      endcase
   end

endmodule

// File: rtl/multi_voice_osc.sv
// Time-multiplexed N-voice stereo tone generator: one voice per cycle after
// each sample tick, mixed into a saturated stereo pair.
module multi_voice_osc
   import audio_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = 16,
   parameter int PERIOD_W   = 11,
   parameter int OUT_W      = 16,
   parameter int MIX_SHIFT  = 3,
   localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
)(
   input  logic                    clk_50mhz,
   input  logic                    reset,
   input  logic                    sample_tick,
   input  logic                    wr_en,
   input  logic [VW-1:0]           wr_voice,
   input  logic [2:0]              wr_addr,
   input  logic [7:0]              wr_data,
   output logic signed [OUT_W-1:0] audio_out_left,
   output logic signed [OUT_W-1:0] audio_out_right,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    overrun
);

   localparam int ACC_W = 24;
   localparam logic [VW-1:0] LAST_SLOT = VW'(NUM_VOICES - 1);

   logic [5:0]         vol     [NUM_VOICES];
   logic [4:0]         pan     [NUM_VOICES];
   logic [7:0]         per_lo  [NUM_VOICES];
   logic [2:0]         per_hi  [NUM_VOICES];
   logic               rpt     [NUM_VOICES];
   wave_t              wave    [NUM_VOICES];
   logic [7:0]         length  [NUM_VOICES];
   logic [7:0]         duty    [NUM_VOICES];
   logic [PHASE_W-1:0] phase   [NUM_VOICES];
   logic [14:0]        lfsr    [NUM_VOICES];
   logic [15:0]        len_cnt [NUM_VOICES];
   logic               active  [NUM_VOICES];
   logic               pending [NUM_VOICES];

   seq_state_t state;
   logic [VW-1:0] slot;
   logic [ACC_W-1:0] acc_l, acc_r, acc_l_nxt, acc_r_nxt, v_ext;

   logic wr_fire, ctrl_wr;
   logic cur_pend, active_eff, silent;
   logic [PHASE_W-1:0] phase_eff, phase_nxt;
   logic [PHASE_W:0] phase_sum;
   logic [PERIOD_W-1:0] period_inc;
   logic [15:0] len_eff, len_nxt;
   logic [14:0] lfsr_nxt;
   logic [7:0] p;
   logic signed [7:0] s;
   logic [13:0] v;
   logic [5:0] gain_l, gain_r;
   logic signed [31:0] wide_l, wide_r, sat_l, sat_r;
   logic unused_ok;

   assign wr_fire   = wr_en && (int'(wr_voice) < NUM_VOICES);
   assign ctrl_wr   = wr_fire && (wr_addr == REG_CTRL);
   assign unused_ok = ^{wr_data[4:3], sat_l[31:OUT_W], sat_r[31:OUT_W]};

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            vol[i]    <= '0;
            pan[i]    <= '0;
            per_lo[i] <= '0;
            per_hi[i] <= '0;
            rpt[i]    <= 1'b0;
            wave[i]   <= SAW;
            length[i] <= '0;
            duty[i]   <= '0;
         end
      end else if (wr_fire) begin
         case (wr_addr)
            REG_VOL:    vol[wr_voice]    <= wr_data[5:0];
            REG_PAN:    pan[wr_voice]    <= wr_data[4:0];
            REG_PER_LO: per_lo[wr_voice] <= wr_data;
            REG_CTRL: begin
               rpt[wr_voice]    <= wr_data[7];
               wave[wr_voice]   <= wave_t'(wr_data[6:5]);
               per_hi[wr_voice] <= wr_data[2:0];
            end
            REG_LEN:    length[wr_voice] <= wr_data;
            REG_DUTY:   duty[wr_voice]   <= wr_data;
            default: ;
         endcase
      end
   end

   wave_shaper u_shaper (
      .p        (p),
      .wave     (wave[slot]),
      .duty     (duty[slot]),
      .lfsr_bit (lfsr[slot][0]),
      .s        (s)
   );

   // A pending retrigger is folded in combinationally so the slot sees the restarted voice.
   always_comb begin
      cur_pend   = pending[slot];
      phase_eff  = cur_pend ? '0 : phase[slot];
      len_eff    = cur_pend ? {length[slot], 8'h00} : len_cnt[slot];
      active_eff = cur_pend | active[slot];
      p          = phase_eff[PHASE_W-1 -: 8];
      period_inc = PERIOD_W'({per_hi[slot], per_lo[slot]});
      phase_sum  = {1'b0, phase_eff} + (PHASE_W + 1)'(period_inc);
      phase_nxt  = phase_sum[PHASE_W-1:0];
      lfsr_nxt   = phase_sum[PHASE_W] ? {lfsr[slot][13:0], lfsr[slot][14] ^ lfsr[slot][13]}
                                      : lfsr[slot];
      silent     = (!rpt[slot] && (len_eff == '0)) || !active_eff;
      len_nxt    = (!silent && !rpt[slot]) ? len_eff - 16'd1 : len_eff;
      v          = silent ? '0 : ({{6{s[7]}}, s} * {8'b0, vol[slot]});
      gain_l     = 6'd32 - {1'b0, pan[slot]};
      gain_r     = {1'b0, pan[slot]};
      v_ext      = {{(ACC_W-14){v[13]}}, v};
      acc_l_nxt  = acc_l + v_ext * {{(ACC_W-6){1'b0}}, gain_l};
      acc_r_nxt  = acc_r + v_ext * {{(ACC_W-6){1'b0}}, gain_r};
      wide_l     = {{(32-ACC_W){acc_l_nxt[ACC_W-1]}}, acc_l_nxt};
      wide_r     = {{(32-ACC_W){acc_r_nxt[ACC_W-1]}}, acc_r_nxt};
      sat_l      = sat_signed(wide_l >>> MIX_SHIFT, OUT_W);
      sat_r      = sat_signed(wide_r >>> MIX_SHIFT, OUT_W);
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state           <= IDLE;
         slot            <= '0;
         acc_l           <= '0;
         acc_r           <= '0;
         audio_out_left  <= '0;
         audio_out_right <= '0;
         out_valid       <= 1'b0;
         busy            <= 1'b0;
         overrun         <= 1'b0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            phase[i]   <= '0;
            lfsr[i]    <= LFSR_SEED;
            len_cnt[i] <= '0;
            active[i]  <= 1'b0;
            pending[i] <= 1'b0;
         end
      end else begin
         out_valid <= 1'b0;
         if (sample_tick && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: if (sample_tick) begin
               acc_l <= '0;
               acc_r <= '0;
               slot  <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               phase[slot]   <= phase_nxt;
               lfsr[slot]    <= lfsr_nxt;
               len_cnt[slot] <= len_nxt;
               active[slot]  <= active_eff;
               pending[slot] <= 1'b0;
               acc_l         <= acc_l_nxt;
               acc_r         <= acc_r_nxt;
               if (slot == LAST_SLOT) begin
                  audio_out_left  <= sat_l[OUT_W-1:0];
                  audio_out_right <= sat_r[OUT_W-1:0];
                  out_valid       <= 1'b1;
                  state           <= OUT;
               end else begin
                  slot <= slot + 1'b1;
               end
            end
            OUT: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Placed after the slot update so a same-cycle write re-arms for the next tick.
         if (ctrl_wr) pending[wr_voice] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multi_voice_osc.sv
// Self-checking bench for multi_voice_osc against an integer reference model.
module tb_multi_voice_osc;

   localparam int NV = 4;

   logic              clk_50mhz = 1'b0;
   logic              reset = 1'b1;
   logic              sample_tick = 1'b0;
   logic              wr_en = 1'b0;
   logic [1:0]        wr_voice = '0;
   logic [2:0]        wr_addr = '0;
   logic [7:0]        wr_data = '0;
   logic signed [15:0] audio_out_left, audio_out_right;
   logic              out_valid, busy, overrun;

   int checks = 0;
   int errors = 0;

   int m_vol[NV], m_pan[NV], m_per[NV], m_rep[NV], m_wave[NV], m_len[NV], m_duty[NV];
   int m_ph[NV], m_lfsr[NV], m_cnt[NV], m_act[NV], m_pend[NV];
   int exp_l, exp_r;

   multi_voice_osc #(.NUM_VOICES(NV), .PHASE_W(16), .PERIOD_W(11), .OUT_W(16), .MIX_SHIFT(3)) dut (
      .clk_50mhz       (clk_50mhz),
      .reset           (reset),
      .sample_tick     (sample_tick),
      .wr_en           (wr_en),
      .wr_voice        (wr_voice),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .audio_out_left  (audio_out_left),
      .audio_out_right (audio_out_right),
      .out_valid       (out_valid),
      .busy            (busy),
      .overrun         (overrun)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NV; i++) begin
         m_vol[i] = 0; m_pan[i] = 0; m_per[i] = 0; m_rep[i] = 0; m_wave[i] = 0;
         m_len[i] = 0; m_duty[i] = 0; m_ph[i] = 0; m_lfsr[i] = 'h7FFF;
         m_cnt[i] = 0; m_act[i] = 0; m_pend[i] = 0;
      end
   endfunction

   function automatic void model_write(input int v, input int a, input int d);
      case (a)
         0: m_vol[v] = d % 64;
         1: m_pan[v] = d % 32;
         2: m_per[v] = (m_per[v] / 256) * 256 + d;
         3: begin
            m_rep[v]  = d / 128;
            m_wave[v] = (d / 32) % 4;
            m_per[v]  = (m_per[v] % 256) + (d % 8) * 256;
            m_pend[v] = 1;
         end
         4: m_len[v]  = d;
         5: m_duty[v] = d;
         default: ;
      endcase
   endfunction

   function automatic int wave_value(input int w, input int p, input int duty, input int noise_bit);
      case (w)
         0: return p - 128;
         1: return ((p < 128) ? 2 * p : 511 - 2 * p) - 128;
         2: return (p < duty) ? 127 : -128;
         default: return noise_bit ? 127 : -127;
      endcase
   endfunction

   function automatic int clamp16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // One sample period of the whole voice bank, in plain integer arithmetic.
   function automatic void model_tick();
      int al, ar, s, vs;
      al = 0; ar = 0;
      for (int i = 0; i < NV; i++) begin
         if (m_pend[i] != 0) begin
            m_ph[i] = 0; m_cnt[i] = m_len[i] * 256; m_pend[i] = 0; m_act[i] = 1;
         end
         s = wave_value(m_wave[i], m_ph[i] / 256, m_duty[i], m_lfsr[i] % 2);
         m_ph[i] = m_ph[i] + m_per[i];
         if (m_ph[i] >= 65536) begin
            m_ph[i] -= 65536;
            m_lfsr[i] = ((m_lfsr[i] * 2) % 32768) + (((m_lfsr[i] / 16384) + (m_lfsr[i] / 8192)) % 2);
         end
         if (m_act[i] != 0 && (m_rep[i] != 0 || m_cnt[i] != 0)) begin
            if (m_rep[i] == 0) m_cnt[i]--;
            vs = s * m_vol[i];
            al += vs * (32 - m_pan[i]);
            ar += vs * m_pan[i];
         end
      end
      exp_l = clamp16(al >>> 3);
      exp_r = clamp16(ar >>> 3);
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk_50mhz);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic wr(input int v, input int a, input int d);
      wr_en = 1'b1; wr_voice = 2'(v); wr_addr = 3'(a); wr_data = 8'(d);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      model_write(v, a, d);
   endtask

   task automatic tick_check(input string tag);
      int n;
      model_tick();
      sample_tick = 1'b1;
      @(negedge clk_50mhz);
      sample_tick = 1'b0;
      check({tag, "_busy"}, busy, 1);
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk_50mhz);
         n++;
      end
      check({tag, "_latency"}, n, NV + 1);
      check({tag, "_left"}, audio_out_left, exp_l);
      check({tag, "_right"}, audio_out_right, exp_r);
      @(negedge clk_50mhz);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int nv_cnt;
      @(negedge clk_50mhz);
      do_reset(4);
      check("rst_left", audio_out_left, 0);
      check("rst_right", audio_out_right, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      nv_cnt = 0;
      repeat (10) begin
         @(negedge clk_50mhz);
         if (out_valid === 1'b1) nv_cnt++;
      end
      check("no_tick_no_valid", nv_cnt, 0);

      // Saw, centre pan, period 1024.
      wr(0, 0, 63); wr(0, 1, 16); wr(0, 2, 0); wr(0, 3, 'h84);
      for (int t = 1; t <= 5; t++) begin
         tick_check("saw");
         if (t == 1) check("saw_t1_value", audio_out_left, -16128);
         if (t == 5) check("saw_t5_value", audio_out_left, -14112);
      end

      // Square, hard left.
      do_reset(2);
      wr(0, 0, 63); wr(0, 1, 0); wr(0, 5, 'h80); wr(0, 2, 0); wr(0, 3, 'hC0);
      tick_check("sq_left");
      check("sq_left_value", audio_out_left, 32004);
      check("sq_right_value", audio_out_right, 0);

      // Four squares together saturate both rails.
      do_reset(2);
      for (int v = 0; v < NV; v++) begin
         wr(v, 0, 63); wr(v, 1, 16); wr(v, 5, 'h80); wr(v, 2, 0);
      end
      for (int v = 0; v < NV; v++) wr(v, 3, 'hC4);
      for (int t = 1; t <= 36; t++) begin
         tick_check("sat");
         if (t == 1) check("sat_high", audio_out_left, 32767);
         if (t == 33) check("sat_low", audio_out_right, -32768);
      end

      // One-shot of 256 samples, then silence, then retrigger.
      do_reset(2);
      wr(0, 0, 63); wr(0, 1, 16); wr(0, 4, 1); wr(0, 2, 0); wr(0, 3, 'h04);
      for (int t = 1; t <= 258; t++) begin
         tick_check("oneshot");
         if (t == 257) check("oneshot_silent", audio_out_left, 0);
      end
      wr(0, 3, 'h04);
      tick_check("oneshot_retrig");
      check("oneshot_restart", audio_out_left, -16128);

      // Tick while busy.
      do_reset(2);
      wr(1, 0, 40); wr(1, 1, 9); wr(1, 2, 'h33); wr(1, 3, 'hA1);
      model_tick();
      sample_tick = 1'b1; @(negedge clk_50mhz);
      sample_tick = 1'b0; @(negedge clk_50mhz);
      sample_tick = 1'b1; @(negedge clk_50mhz);
      sample_tick = 1'b0;
      nv_cnt = 0;
      repeat (20) begin
         if (out_valid === 1'b1) begin
            nv_cnt++;
            check("ovr_left", audio_out_left, exp_l);
            check("ovr_right", audio_out_right, exp_r);
         end
         @(negedge clk_50mhz);
      end
      check("ovr_one_valid", nv_cnt, 1);
      check("ovr_set", overrun, 1);
      repeat (5) @(negedge clk_50mhz);
      check("ovr_sticky", overrun, 1);
      do_reset(1);
      check("ovr_cleared", overrun, 0);

      // Reset in the middle of a sequence.
      wr(0, 0, 63); wr(0, 1, 16); wr(0, 3, 'h84);
      sample_tick = 1'b1; @(negedge clk_50mhz);
      sample_tick = 1'b0; @(negedge clk_50mhz);
      reset = 1'b1; @(negedge clk_50mhz);
      reset = 1'b0;
      model_reset();
      nv_cnt = 0;
      repeat (10) begin
         if (out_valid === 1'b1) nv_cnt++;
         @(negedge clk_50mhz);
      end
      check("abort_no_valid", nv_cnt, 0);
      check("abort_busy", busy, 0);
      check("abort_left", audio_out_left, 0);

      // Randomised voice configurations, including writes to unused addresses.
      do_reset(2);
      for (int v = 0; v < NV; v++) begin
         wr(v, 0, $urandom_range(0, 63));
         wr(v, 1, $urandom_range(0, 31));
         wr(v, 2, $urandom_range(0, 255));
         wr(v, 4, $urandom_range(0, 2));
         wr(v, 5, $urandom_range(0, 255));
         wr(v, $urandom_range(6, 7), $urandom_range(0, 255));
         wr(v, 3, $urandom_range(0, 255));
      end
      for (int t = 1; t <= 60; t++) begin
         if (t % 12 == 0) begin
            wr($urandom_range(0, NV - 1), 3, $urandom_range(0, 255));
            wr($urandom_range(0, NV - 1), $urandom_range(0, 2), $urandom_range(0, 255));
         end
         repeat ($urandom_range(0, 4)) @(negedge clk_50mhz);
         tick_check("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
